// File: rtl/ej1_pkg.sv
// Shared types and width constants for the selective-adder/accumulator
// response checker (acc_checker) and its reference model.
package ej1_pkg;

    localparam int DATA_W_DEF = 3;
    localparam int SUM_W      = DATA_W_DEF + 1;
    localparam int ACC_W      = 2 * DATA_W_DEF;

    // Select-stage operation, encoded as on the DUT's i_sel pins
    typedef enum logic [1:0] {
        SEL_SUB  = 2'b00,
        SEL_ADD  = 2'b01,
        SEL_A    = 2'b10,
        SEL_ZERO = 2'b11
    } sel_e;

    // Checker run-control states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        PASS = 2'b10,
        FAIL = 2'b11
    } chk_state_e;

endpackage

// File: rtl/acc_ref_model.sv
// Cycle-accurate reference of the DUT datapath: select stage feeding a
// wrapping accumulator with an optional sticky overflow flag.
// Optional feature macro: ACC_CHK_OVF_EN (adds the overflow model).
module acc_ref_model
    import ej1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clock,
    input  logic                  i_dut_rst_n,
    input  logic [1:0]            i_sel,
    input  logic [DATA_W-1:0]     i_data1,
    input  logic [DATA_W-1:0]     i_data2,
    output logic [2*DATA_W-1:0]   o_acc,
    output logic                  o_ovf
);

    localparam int SW = DATA_W + 1;
    localparam int AW = 2 * DATA_W;

    logic [SW-1:0] sel_out;
    logic [AW-1:0] acc;
    logic [AW-1:0] sel_ext;

    // Select stage; subtraction wraps modulo 2^(DATA_W+1) like the DUT
    always_comb begin
        sel_out = '0;
        case (sel_e'(i_sel))
            SEL_SUB:  sel_out = {1'b0, i_data1} - {1'b0, i_data2};
            SEL_ADD:  sel_out = {1'b0, i_data1} + {1'b0, i_data2};
            SEL_A:    sel_out = {1'b0, i_data1};
            default:  sel_out = '0;
        endcase
    end

    assign sel_ext = {{(AW-SW){1'b0}}, sel_out};
    assign o_acc   = acc;

`ifdef ACC_CHK_OVF_EN
    logic [AW:0] sum;
    logic        ovf;

    assign sum   = {1'b0, acc} + {1'b0, sel_ext};
    assign o_ovf = ovf;

    // Accumulator and sticky overflow, cleared with the DUT's own reset
    always_ff @(posedge clock or negedge i_dut_rst_n) begin
        if (!i_dut_rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= sum[AW-1:0];
            ovf <= ovf | sum[AW];
        end
    end
`else
    assign o_ovf = 1'b0;

    // Wrapping accumulator, cleared with the DUT's own reset
    always_ff @(posedge clock or negedge i_dut_rst_n) begin
        if (!i_dut_rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc + sel_ext;
        end
    end
`endif

endmodule

// File: rtl/acc_checker.sv
// Response checker for the selective-adder/accumulator: mirrors the DUT
// inputs into acc_ref_model, compares every cycle of an armed run, counts
// mismatches (saturating) and captures the first failing sample.
// Optional feature macro: ACC_CHK_OVF_EN (also compares i_dut_ovf).
module acc_checker
    import ej1_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CYC_W       = 16,
    parameter int ERR_W       = 8,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic                  clock,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [CYC_W-1:0]      i_num_cyc,
    input  logic                  i_dut_rst_n,
    input  logic [1:0]            i_sel,
    input  logic [DATA_W-1:0]     i_data1,
    input  logic [DATA_W-1:0]     i_data2,
    input  logic [2*DATA_W-1:0]   i_dut_data,
    input  logic                  i_dut_ovf,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [ERR_W-1:0]      o_err_cnt,
    output logic [CYC_W-1:0]      o_first_cyc,
    output logic [2*DATA_W-1:0]   o_first_exp,
    output logic [2*DATA_W-1:0]   o_first_got
);

    localparam int AW = 2 * DATA_W;

    chk_state_e     state;
    logic [AW-1:0]  m_acc;
    logic           m_ovf;
    logic           rst_q;
    logic           cmp_en;
    logic           data_mis;
    logic           ovf_mis;
    logic           mismatch;
    logic           last_cyc;
    logic           err_sat;

    logic [CYC_W-1:0] num_q;
    logic [CYC_W-1:0] cyc_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic [CYC_W-1:0] first_cyc;
    logic [AW-1:0]    first_exp;
    logic [AW-1:0]    first_got;
    logic             busy;
    logic             done;
    logic             pass;

    acc_ref_model #(
        .DATA_W      (DATA_W)
    ) u_model (
        .clock       (clock),
        .i_dut_rst_n (i_dut_rst_n),
        .i_sel       (i_sel),
        .i_data1     (i_data1),
        .i_data2     (i_data2),
        .o_acc       (m_acc),
        .o_ovf       (m_ovf)
    );

    // Remember last cycle's DUT reset so the cycle right after release is masked
    always_ff @(posedge clock) begin
        if (i_rst) begin
            rst_q <= 1'b0;
        end else begin
            rst_q <= i_dut_rst_n;
        end
    end

    // Async-reset skew: skip cycles under DUT reset and the first one after it
    assign cmp_en   = i_dut_rst_n & rst_q;
    assign data_mis = (i_dut_data != m_acc);

`ifdef ACC_CHK_OVF_EN
    assign ovf_mis  = (i_dut_ovf != m_ovf);
`else
    logic unused_ovf;
    assign unused_ovf = i_dut_ovf ^ m_ovf;
    assign ovf_mis    = 1'b0;
`endif

    assign mismatch = cmp_en & (data_mis | ovf_mis);
    assign last_cyc = (cyc_cnt == num_q - CYC_W'(1));
    assign err_sat  = (err_cnt == {ERR_W{1'b1}});

    // Run control, counters and first-mismatch capture with registered outputs
    always_ff @(posedge clock) begin
        if (i_rst) begin
            state     <= IDLE;
            num_q     <= '0;
            cyc_cnt   <= '0;
            err_cnt   <= '0;
            first_cyc <= '0;
            first_exp <= '0;
            first_got <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    if (num_q == '0) begin
                        // Empty run: finish on the first cycle, nothing compared
                        state <= PASS;
                        busy  <= 1'b0;
                        pass  <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        if (mismatch) begin
                            if (err_cnt == '0) begin
                                first_cyc <= cyc_cnt;
                                first_exp <= m_acc;
                                first_got <= i_dut_data;
                            end
                            if (!err_sat) begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                        end
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                        if ((STOP_ON_ERR && mismatch) || last_cyc) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            if (mismatch || (err_cnt != '0)) begin
                                state <= FAIL;
                            end else begin
                                state <= PASS;
                                pass  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE, PASS and FAIL all hold results until re-armed
                    if (i_start) begin
                        state     <= RUN;
                        num_q     <= i_num_cyc;
                        cyc_cnt   <= '0;
                        err_cnt   <= '0;
                        first_cyc <= '0;
                        first_exp <= '0;
                        first_got <= '0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_busy      = busy;
    assign o_done      = done;
    assign o_pass      = pass;
    assign o_err_cnt   = err_cnt;
    assign o_first_cyc = first_cyc;
    assign o_first_exp = first_exp;
    assign o_first_got = first_got;

endmodule

// File: tb/tb_acc_checker.sv
// Bench for acc_checker: two instances (stop-on-error and run-through) share
// one stimulus stream; a behavioural model of the accumulator and of the run
// rules predicts every result.
module tb_acc_checker;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PASS = 2;
    localparam int M_FAIL = 3;

`ifdef ACC_CHK_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst, start, dut_rst_n, dut_ovf;
    logic [1:0]  sel;
    logic [2:0]  d1, d2;
    logic [15:0] num_cyc;
    logic [5:0]  dut_data;

    logic        s_busy, s_done, s_pass, ns_busy, ns_done, ns_pass;
    logic [7:0]  s_err, ns_err;
    logic [15:0] s_fcyc, ns_fcyc;
    logic [5:0]  s_fexp, s_fgot, ns_fexp, ns_fgot;

    always #5 clock = ~clock;

    acc_checker #(.DATA_W(3), .CYC_W(16), .ERR_W(8), .STOP_ON_ERR(1'b1)) dut (
        .clock(clock), .i_rst(rst), .i_start(start), .i_num_cyc(num_cyc),
        .i_dut_rst_n(dut_rst_n), .i_sel(sel), .i_data1(d1), .i_data2(d2),
        .i_dut_data(dut_data), .i_dut_ovf(dut_ovf),
        .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass), .o_err_cnt(s_err),
        .o_first_cyc(s_fcyc), .o_first_exp(s_fexp), .o_first_got(s_fgot));

    acc_checker #(.DATA_W(3), .CYC_W(16), .ERR_W(8), .STOP_ON_ERR(1'b0)) dut_ns (
        .clock(clock), .i_rst(rst), .i_start(start), .i_num_cyc(num_cyc),
        .i_dut_rst_n(dut_rst_n), .i_sel(sel), .i_data1(d1), .i_data2(d2),
        .i_dut_data(dut_data), .i_dut_ovf(dut_ovf),
        .o_busy(ns_busy), .o_done(ns_done), .o_pass(ns_pass), .o_err_cnt(ns_err),
        .o_first_cyc(ns_fcyc), .o_first_exp(ns_fexp), .o_first_got(ns_fgot));

    int errors = 0;
    int checks = 0;

    // Behavioural model state: accumulator as a plain integer, run bookkeeping
    // per instance (index 0 stops on error, index 1 runs through)
    int   acc_m;
    bit   ovf_m, prev_rstn;
    logic [5:0] dmask;
    logic oflip;
    int   m_state[2], m_idx[2], m_errs[2], m_num[2], m_fcyc[2], m_fexp[2], m_fgot[2];
    bit   m_done[2];

    function automatic int sel_val(int s, int a, int b);
        case (s)
            0: return (a - b) & 15;
            1: return a + b;
            2: return a;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit en, mism;
        en   = dut_rst_n && prev_rstn;
        mism = en && ((int'(dut_data) != acc_m) || (OVF_EN && (dut_ovf != ovf_m)));
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            if (rst) begin
                m_state[k] = M_IDLE; m_idx[k] = 0; m_errs[k] = 0;
                m_fcyc[k] = 0; m_fexp[k] = 0; m_fgot[k] = 0;
            end else if (m_state[k] == M_RUN) begin
                if (m_num[k] == 0) begin
                    m_state[k] = M_PASS; m_done[k] = 1'b1;
                end else begin
                    if (mism) begin
                        if (m_errs[k] == 0) begin
                            m_fcyc[k] = m_idx[k]; m_fexp[k] = acc_m; m_fgot[k] = int'(dut_data);
                        end
                        if (m_errs[k] < 255) m_errs[k]++;
                    end
                    m_idx[k]++;
                    if ((k == 0 && mism) || m_idx[k] == m_num[k]) begin
                        m_state[k] = (m_errs[k] == 0) ? M_PASS : M_FAIL;
                        m_done[k]  = 1'b1;
                    end
                end
            end else if (start) begin
                m_state[k] = M_RUN; m_idx[k] = 0; m_errs[k] = 0; m_num[k] = int'(num_cyc);
                m_fcyc[k] = 0; m_fexp[k] = 0; m_fgot[k] = 0;
            end
        end
        if (!dut_rst_n) begin
            acc_m = 0; ovf_m = 1'b0;
        end else begin
            acc_m += sel_val(int'(sel), int'(d1), int'(d2));
            if (acc_m >= 64) begin ovf_m = 1'b1; acc_m -= 64; end
        end
        prev_rstn = dut_rst_n;
    endtask

    // One clock: present the (possibly corrupted) DUT response, advance model
    task automatic tick();
        dut_data = 6'(acc_m) ^ dmask;
        dut_ovf  = ovf_m ^ oflip;
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    // Bring the DUT accumulator to a known zero, then hold it with sel=11
    task automatic clear_acc();
        dut_rst_n = 1'b0; sel = 2'b11; dmask = '0; oflip = 1'b0;
        tick();
        dut_rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (s_busy !== 1'b0 || s_done !== 1'b0 || s_pass !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b%b exp=000", s_busy, s_done, s_pass); end
        checks++; if (s_err !== 8'd0 || s_fcyc !== 16'd0) begin errors++; $display("FAIL reset_cnt got err=%0d cyc=%0d exp=0", s_err, s_fcyc); end
        checks++; if (s_fexp !== 6'd0 || s_fgot !== 6'd0) begin errors++; $display("FAIL reset_cap got=%0d/%0d exp=0", s_fexp, s_fgot); end
        checks++; if (ns_busy !== 1'b0 || ns_pass !== 1'b0 || ns_err !== 8'd0) begin errors++; $display("FAIL reset_ns got=%b%b %0d exp=0", ns_busy, ns_pass, ns_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dut_in_reset();
        dut_rst_n = 1'b0; d1 = 3'd2; d2 = 3'd1; sel = 2'b00;
        start = 1'b1; num_cyc = 16'd8;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12 && m_state[0] == M_RUN; i++) begin
            sel = 2'(i); dmask = 6'($urandom);
            tick();
        end
        dmask = '0;
        checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL inrst_done got=%b exp=1", s_done); end
        checks++; if (s_pass !== 1'b1 || s_busy !== 1'b0) begin errors++; $display("FAIL inrst_pass got=%b busy=%b exp=1/0", s_pass, s_busy); end
        checks++; if (s_err !== 8'd0) begin errors++; $display("FAIL inrst_err got=%0d exp=0", s_err); end
        tick();
        checks++; if (s_done !== 1'b0 || s_pass !== 1'b1) begin errors++; $display("FAIL inrst_hold got done=%b pass=%b exp=0/1", s_done, s_pass); end
    endtask

    task automatic test_wrap();
        clear_acc();
        sel = 2'b01; d1 = 3'd1; d2 = 3'd1; start = 1'b1; num_cyc = 16'd40;
        tick();
        start = 1'b0;
        for (int i = 0; i < 45 && m_state[1] == M_RUN; i++) tick();
        checks++; if (s_done !== 1'b1 || s_pass !== 1'b1) begin errors++; $display("FAIL wrap_pass got done=%b pass=%b exp=1/1", s_done, s_pass); end
        checks++; if (s_err !== 8'd0 || ns_err !== 8'd0) begin errors++; $display("FAIL wrap_err got=%0d/%0d exp=0", s_err, ns_err); end
        checks++; if (ns_pass !== 1'b1) begin errors++; $display("FAIL wrap_ns_pass got=%b exp=1", ns_pass); end
    endtask

    task automatic test_stop_on_err();
        clear_acc();
        sel = 2'b01; d1 = 3'd1; d2 = 3'd1; start = 1'b1; num_cyc = 16'd40;
        tick();
        start = 1'b0;
        for (int i = 0; i < 45 && m_state[1] == M_RUN; i++) begin
            dmask = (m_idx[1] == 5) ? 6'd1 : 6'd0;
            tick();
            if (m_done[0]) begin
                checks++; if (s_done !== 1'b1 || s_pass !== 1'b0) begin errors++; $display("FAIL stop_done got done=%b pass=%b exp=1/0", s_done, s_pass); end
            end
        end
        dmask = '0;
        checks++; if (s_err !== 8'd1 || s_fcyc !== 16'd5) begin errors++; $display("FAIL stop_cnt got err=%0d cyc=%0d exp=1/5", s_err, s_fcyc); end
        checks++; if (s_fexp !== 6'd12 || s_fgot !== 6'd13) begin errors++; $display("FAIL stop_cap got exp=%0d got=%0d req=12/13", s_fexp, s_fgot); end
        checks++; if (ns_err !== 8'd1 || ns_pass !== 1'b0 || ns_done !== 1'b1) begin errors++; $display("FAIL stop_ns got err=%0d pass=%b done=%b exp=1/0/1", ns_err, ns_pass, ns_done); end
    endtask

    task automatic test_ovf_force();
        int cnt;
        cnt = 0;
        clear_acc();
        sel = 2'b01; d1 = 3'd1; d2 = 3'd1; start = 1'b1; num_cyc = 16'd45;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && m_state[1] == M_RUN; i++) begin
            oflip = (ovf_m && cnt < 10) ? 1'b1 : 1'b0;
            if (oflip) cnt++;
            tick();
        end
        oflip = 1'b0;
        checks++; if (ns_err !== (OVF_EN ? 8'd10 : 8'd0)) begin errors++; $display("FAIL ovf_err got=%0d exp=%0d", ns_err, OVF_EN ? 10 : 0); end
        checks++; if (ns_pass !== !OVF_EN || ns_done !== 1'b1) begin errors++; $display("FAIL ovf_pass got pass=%b done=%b exp=%b/1", ns_pass, ns_done, !OVF_EN); end
        checks++; if (s_pass !== (m_state[0] == M_PASS) || s_err !== 8'(m_errs[0])) begin errors++; $display("FAIL ovf_stop got pass=%b err=%0d exp=%0d", s_pass, s_err, m_errs[0]); end
    endtask

    task automatic test_dut_rst_pulse();
        start = 1'b1; num_cyc = 16'd20;
        tick();
        start = 1'b0;
        for (int i = 0; i < 25 && m_state[1] == M_RUN; i++) begin
            sel = 2'($urandom); d1 = 3'($urandom); d2 = 3'($urandom);
            dut_rst_n = !(m_idx[1] >= 6 && m_idx[1] <= 8);
            dmask = (m_idx[1] >= 6 && m_idx[1] <= 9) ? 6'($urandom_range(1, 63)) : 6'd0;
            tick();
        end
        dut_rst_n = 1'b1; dmask = '0;
        checks++; if (s_pass !== 1'b1 || s_done !== 1'b1) begin errors++; $display("FAIL rstpulse_pass got pass=%b done=%b exp=1/1", s_pass, s_done); end
        checks++; if (s_err !== 8'd0 || ns_err !== 8'd0) begin errors++; $display("FAIL rstpulse_err got=%0d/%0d exp=0", s_err, ns_err); end
    endtask

    task automatic test_rst_mid_run();
        start = 1'b1; num_cyc = 16'd20;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dmask = (i == 3) ? 6'd1 : 6'd0;
            tick();
        end
        dmask = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (s_busy !== 1'b0 || s_done !== 1'b0 || s_pass !== 1'b0) begin errors++; $display("FAIL midrst_flags got=%b%b%b exp=000", s_busy, s_done, s_pass); end
        checks++; if (s_err !== 8'd0 || s_fcyc !== 16'd0 || s_fexp !== 6'd0 || s_fgot !== 6'd0) begin errors++; $display("FAIL midrst_cap got err=%0d cyc=%0d exp=%0d got=%0d req=0", s_err, s_fcyc, s_fexp, s_fgot); end
        checks++; if (ns_busy !== 1'b0 || ns_err !== 8'd0 || ns_fcyc !== 16'd0) begin errors++; $display("FAIL midrst_ns got busy=%b err=%0d cyc=%0d exp=0", ns_busy, ns_err, ns_fcyc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_done !== 1'b0 || ns_done !== 1'b0) begin errors++; $display("FAIL midrst_nodone got=%b/%b exp=0", s_done, ns_done); end
        end
    endtask

    task automatic test_num_zero();
        start = 1'b1; num_cyc = 16'd0;
        tick();
        start = 1'b0;
        checks++; if (s_busy !== 1'b1 || s_done !== 1'b0) begin errors++; $display("FAIL zero_arm got busy=%b done=%b exp=1/0", s_busy, s_done); end
        tick();
        checks++; if (s_done !== 1'b1 || s_pass !== 1'b1 || ns_done !== 1'b1) begin errors++; $display("FAIL zero_end got done=%b pass=%b ns=%b exp=1/1/1", s_done, s_pass, ns_done); end
        tick();
        checks++; if (s_done !== 1'b0 || s_pass !== 1'b1) begin errors++; $display("FAIL zero_hold got done=%b pass=%b exp=0/1", s_done, s_pass); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; num_cyc = 16'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8 && m_state[1] == M_RUN; i++) begin
            sel = 2'($urandom); d1 = 3'($urandom); d2 = 3'($urandom);
            dmask = (m_idx[1] == 1) ? 6'd4 : 6'd0;
            tick();
        end
        dmask = '0;
        checks++; if (ns_pass !== 1'b0 || ns_err !== 8'd1 || ns_fcyc !== 16'd1) begin errors++; $display("FAIL b2b_first got pass=%b err=%0d cyc=%0d exp=0/1/1", ns_pass, ns_err, ns_fcyc); end
        start = 1'b1; num_cyc = 16'd3;
        tick();
        start = 1'b0;
        checks++; if (ns_err !== 8'd0 || ns_fcyc !== 16'd0 || ns_fgot !== 6'd0 || ns_busy !== 1'b1) begin errors++; $display("FAIL b2b_clear got err=%0d cyc=%0d got=%0d busy=%b exp=0/0/0/1", ns_err, ns_fcyc, ns_fgot, ns_busy); end
        for (int i = 0; i < 6 && m_state[1] == M_RUN; i++) tick();
        checks++; if (ns_pass !== 1'b1 || s_pass !== 1'b1 || ns_done !== 1'b1) begin errors++; $display("FAIL b2b_second got pass=%b/%b done=%b exp=1/1/1", s_pass, ns_pass, ns_done); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            start = 1'b1; num_cyc = 16'($urandom_range(1, 30));
            tick();
            start = 1'b0;
            for (int c = 0; c < int'(num_cyc) + 5 && (m_state[0] == M_RUN || m_state[1] == M_RUN); c++) begin
                sel = 2'($urandom); d1 = 3'($urandom); d2 = 3'($urandom);
                dmask = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
                oflip = ($urandom_range(0, 9) == 0);
                dut_rst_n = ($urandom_range(0, 15) != 0);
                tick();
                checks++; if (s_done !== m_done[0] || ns_done !== m_done[1]) begin errors++; $display("FAIL rnd%0d_done got=%b/%b exp=%b/%b", r, s_done, ns_done, m_done[0], m_done[1]); end
            end
            dut_rst_n = 1'b1; dmask = '0; oflip = 1'b0;
            checks++; if (s_pass !== (m_state[0] == M_PASS) || s_busy !== (m_state[0] == M_RUN) || s_err !== 8'(m_errs[0])) begin errors++; $display("FAIL rnd%0d_stop got pass=%b busy=%b err=%0d exp err=%0d st=%0d", r, s_pass, s_busy, s_err, m_errs[0], m_state[0]); end
            checks++; if (s_fcyc !== 16'(m_fcyc[0]) || s_fexp !== 6'(m_fexp[0]) || s_fgot !== 6'(m_fgot[0])) begin errors++; $display("FAIL rnd%0d_stopcap got %0d/%0d/%0d exp %0d/%0d/%0d", r, s_fcyc, s_fexp, s_fgot, m_fcyc[0], m_fexp[0], m_fgot[0]); end
            checks++; if (ns_pass !== (m_state[1] == M_PASS) || ns_err !== 8'(m_errs[1])) begin errors++; $display("FAIL rnd%0d_run got pass=%b err=%0d exp err=%0d st=%0d", r, ns_pass, ns_err, m_errs[1], m_state[1]); end
            checks++; if (ns_fcyc !== 16'(m_fcyc[1]) || ns_fexp !== 6'(m_fexp[1]) || ns_fgot !== 6'(m_fgot[1])) begin errors++; $display("FAIL rnd%0d_runcap got %0d/%0d/%0d exp %0d/%0d/%0d", r, ns_fcyc, ns_fexp, ns_fgot, m_fcyc[1], m_fexp[1], m_fgot[1]); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dut_rst_n = 1'b0; sel = '0; d1 = '0; d2 = '0;
        num_cyc = '0; dmask = '0; oflip = 1'b0; dut_data = '0; dut_ovf = 1'b0;
        acc_m = 0; ovf_m = 1'b0; prev_rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = M_IDLE; m_idx[k] = 0; m_errs[k] = 0; m_num[k] = 0;
            m_fcyc[k] = 0; m_fexp[k] = 0; m_fgot[k] = 0; m_done[k] = 1'b0;
        end
        @(negedge clock);
        test_reset();
        test_dut_in_reset();
        test_wrap();
        test_stop_on_err();
        test_ovf_force();
        test_dut_rst_pulse();
        test_rst_mid_run();
        test_num_zero();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc_checker.md
# acc_checker

Synthesizable response checker for the selective-adder/accumulator top level (`top_ej_1`). It sits on the DUT's output side and mirrors its operand and select inputs into a cycle-accurate reference model. Each cycle it compares the model against the DUT's `o_data`/`o_overflow`, counts mismatches and latches the first failure. Verification uses it in simulation and on-board, where a logic analyzer cannot follow the accumulator state.

## Interface
Parameters:
- `DATA_W`, 3: operand width. Select-stage result is `DATA_W+1`; accumulator is `2*DATA_W`.
- `CYC_W`, 16: width of the run-length and cycle counters.
- `ERR_W`, 8: width of the error counter; saturates at its maximum.
- `STOP_ON_ERR`, 1: when 1, the FSM goes to FAIL on the first mismatch. When 0, it keeps running and counting.

Ports:
- `clock` in 1: single clock, rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: one-cycle pulse; arms a run.
- `i_num_cyc` in CYC_W: number of compared cycles in the run; sampled on `i_start`.
- `i_dut_rst_n` in 1: copy of the DUT's asynchronous active-low reset.
- `i_sel` in 2: copy of DUT select.
- `i_data1`, `i_data2` in DATA_W: copies of DUT operands.
- `i_dut_data` in 2*DATA_W: DUT `o_data`.
- `i_dut_ovf` in 1: DUT `o_overflow`.
- `o_busy` out 1: high in RUN.
- `o_done` out 1: one-cycle pulse when a run ends (PASS or FAIL).
- `o_pass` out 1: level; high in PASS.
- `o_err_cnt` out ERR_W: number of mismatches.
- `o_first_cyc` out CYC_W: index of the cycle with the first mismatch.
- `o_first_exp`, `o_first_got` out 2*DATA_W: expected and actual data at the first mismatch.

## Operation
- Reference select stage, combinational, `DATA_W+1` bits:
  - sel 00: `data1-data2` modulo 2^(DATA_W+1).
  - sel 01: `data1+data2`.
  - sel 10: `data1`, zero-extended.
  - sel 11: 0.
- Reference accumulator, updated every clock:
  - While `i_dut_rst_n`=0: `acc`=0 and `ovf`=0.
  - Otherwise: `{carry,acc} <= acc + zext(sel_out)`, and `ovf <= ovf | carry`.
  - `ovf` is sticky until the DUT is reset. `acc` wraps modulo 2^(2*DATA_W).
- FSM states and transitions:
  - IDLE: on `i_start`, clear the counters and error capture, load `i_num_cyc`, go to RUN.
  - RUN: compare each cycle. Go to FAIL on the first mismatch if `STOP_ON_ERR`=1. When the cycle counter reaches `i_num_cyc`, go to PASS if `err_cnt`=0, else FAIL.
  - PASS and FAIL: hold all results. `i_start` re-arms and goes to RUN.
- Compare gating: no comparison while `i_dut_rst_n`=0, and none in the first cycle after it rises. This masks the asynchronous-reset skew. Gated cycles still count toward `i_num_cyc`.
- A mismatch is `i_dut_data != acc`. With `ACC_CHK_OVF_EN` it also includes `i_dut_ovf != ovf`.
- First-mismatch capture loads only when `err_cnt`=0.
- `i_num_cyc`=0: the run ends on the cycle after `i_start` with PASS, and `o_done` pulses.
- `i_start` during RUN is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - The model `acc` and `ovf` are 0.
- The model register updates on the same edge as the DUT register. The comparison at edge N uses the model value and the DUT output, both registered at edge N-1. The check is therefore zero-latency relative to the DUT.
- Error counter and capture registers update one cycle after the mismatching sample.
- `o_done` rises one cycle after the last compared cycle.
- `i_rst` asserted mid-run: the next edge returns the block to IDLE and clears all outputs. No `o_done` pulse is produced.

## Configuration
- `ACC_CHK_OVF_EN`:
  - Defined: the overflow model and the `i_dut_ovf` comparison are included.
  - Undefined: `i_dut_ovf` is ignored, and the model's `ovf`/carry logic is removed; only data is checked.

## Structure
- Package `ej1_pkg` holds:
  - Width constants `DATA_W_DEF=3`, `SUM_W`, `ACC_W`.
  - Enum `sel_e` (`SEL_SUB`, `SEL_ADD`, `SEL_A`, `SEL_ZERO`).
  - FSM state enum `chk_state_e` (IDLE, RUN, PASS, FAIL).
- Sub-module `acc_ref_model` holds the select stage and accumulator/overflow registers. Its interface is `clock`, `i_dut_rst_n`, `i_sel`, `i_data1`, `i_data2`, `o_acc`, `o_ovf`. The FSM, counters and capture stay in `acc_checker`.

## Test plan
- DUT in reset, data1=2, data2=1, sel cycled 00/01/10/11, `i_num_cyc`=8 -> PASS, `o_err_cnt`=0. Model `acc` stays 0.
- sel=01, data1=data2=1, DUT released, `i_num_cyc`=40 -> model `acc` wraps after 32 cycles. With `ACC_CHK_OVF_EN`: `ovf`=1 from cycle 33, PASS.
- Same run with `i_dut_data` bit 0 forced at cycle 5, `STOP_ON_ERR`=1 -> FAIL. `o_first_cyc`=5, `o_first_exp`=12, `o_first_got`=13, `o_err_cnt`=1.
- `STOP_ON_ERR`=0, `i_dut_ovf` forced 0 for 10 cycles after overflow:
  - With the macro: `o_err_cnt`=10, FAIL.
  - Without the macro: PASS.
- `i_dut_rst_n` pulsed low mid-run -> model clears; cycles under reset plus one following are not compared; PASS.
- `i_rst` asserted during RUN -> IDLE next edge, all outputs 0, no `o_done`. `i_num_cyc`=0 run -> `o_done` and `o_pass` one cycle after `i_start`.
